// File: rtl/dense_layer_batched_if.sv
// Handshake and operand bus for dense_layer_batched: the layer controller drives
// start and holds x/w/b stable; the layer returns busy, done and y.
interface dense_layer_batched_if #(
    parameter int BITSIZE  = 16,
    parameter int IN_SIZE  = 92,
    parameter int OUT_SIZE = 4
);
    logic                                  start;
    logic [BITSIZE*IN_SIZE-1:0]            x;
    logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0]   w;
    logic [BITSIZE*OUT_SIZE-1:0]           b;
    logic                                  busy;
    logic                                  done;
    logic [BITSIZE*OUT_SIZE-1:0]           y;

    modport master (output start, x, w, b, input busy, done, y);
    modport slave  (input start, x, w, b, output busy, done, y);
endinterface

// File: rtl/dense_layer_batched.sv
// Fully-connected layer y = act(W*x + b), BATCH signed fixed-point products per
// output channel per cycle, exact accumulation, saturating output, optional ReLU.
module dense_layer_batched #(
    parameter int BITSIZE   = 16,
    parameter int FRAC_BITS = 8,
    parameter int IN_SIZE   = 92,
    parameter int OUT_SIZE  = 4,
    parameter int BATCH     = 32,
    parameter int RELU      = 0
) (
    input logic               clk,
    input logic               reset,
    dense_layer_batched_if.slave bus
);

    localparam int BC   = (IN_SIZE + BATCH - 1) / BATCH;
    localparam int BIW  = (BC > 1) ? $clog2(BC) : 1;
    localparam int ACCW = BITSIZE + FRAC_BITS + $clog2(IN_SIZE + 1);
    localparam int PW   = 2 * BITSIZE;
    localparam int EW   = (ACCW > PW) ? ACCW : PW;
    localparam int NPAD = BC * BATCH;

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (BITSIZE - 1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [BIW-1:0]         LAST_BIDX = BIW'(BC - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [BIW-1:0]           bidx_q, bidx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [BITSIZE*OUT_SIZE-1:0] y_q, y_d;
    logic signed [ACCW-1:0]   acc_q [OUT_SIZE];
    logic signed [ACCW-1:0]   acc_d [OUT_SIZE];
    logic signed [PW-1:0]     prod_q [OUT_SIZE][BATCH];
    logic signed [PW-1:0]     prod_d [OUT_SIZE][BATCH];

    logic signed [BITSIZE-1:0] x_pad  [NPAD];
    logic signed [BITSIZE-1:0] w_pad  [OUT_SIZE][NPAD];
    logic signed [BITSIZE-1:0] lane_x [BATCH];
    logic signed [BITSIZE-1:0] lane_w [OUT_SIZE][BATCH];
    logic signed [EW-1:0]      batch_sum [OUT_SIZE];

    // Pad operands to a whole number of batches so lanes past IN_SIZE multiply zero.
    always_comb begin
        for (int unsigned i = 0; i < IN_SIZE; i++) begin
            x_pad[i] = bus.x[i*BITSIZE +: BITSIZE];
            for (int unsigned o = 0; o < OUT_SIZE; o++)
                w_pad[o][i] = bus.w[(o*IN_SIZE + i)*BITSIZE +: BITSIZE];
        end
        for (int unsigned i = IN_SIZE; i < NPAD; i++) begin
            x_pad[i] = '0;
            for (int unsigned o = 0; o < OUT_SIZE; o++)
                w_pad[o][i] = '0;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < BATCH; j++) begin
            lane_x[j] = '0;
            for (int unsigned o = 0; o < OUT_SIZE; o++)
                lane_w[o][j] = '0;
            for (int unsigned k = 0; k < BC; k++) begin
                if (bidx_q == BIW'(k)) begin
                    lane_x[j] = x_pad[k*BATCH + j];
                    for (int unsigned o = 0; o < OUT_SIZE; o++)
                        lane_w[o][j] = w_pad[o][k*BATCH + j];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < OUT_SIZE; o++) begin
            batch_sum[o] = '0;
            for (int unsigned j = 0; j < BATCH; j++) begin
                prod_d[o][j] = (PW'(lane_x[j]) * PW'(lane_w[o][j])) >>> FRAC_BITS;
                batch_sum[o] = batch_sum[o] + EW'(prod_q[o][j]);
            end
        end
    end

    function automatic logic [BITSIZE-1:0] act_sat(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] a;
        a = v;
        if (RELU != 0 && a < 0)
            a = '0;
        if (a > SAT_MAX)
            a = SAT_MAX;
        else if (a < SAT_MIN)
            a = SAT_MIN;
        return a[BITSIZE-1:0];
    endfunction

    // Products are registered one cycle ahead of their accumulation, so the
    // first MUL cycle only fills the pipeline and DRAIN adds the final batch.
    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int unsigned o = 0; o < OUT_SIZE; o++)
                        acc_d[o] = ACCW'($signed(bus.b[o*BITSIZE +: BITSIZE]));
                    bidx_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (bidx_q != '0) begin
                    for (int unsigned o = 0; o < OUT_SIZE; o++)
                        acc_d[o] = ACCW'(EW'(acc_q[o]) + batch_sum[o]);
                end
                if (bidx_q == LAST_BIDX)
                    state_d = S_DRAIN;
                else
                    bidx_d = bidx_q + 1'b1;
            end
            S_DRAIN: begin
                for (int unsigned o = 0; o < OUT_SIZE; o++)
                    acc_d[o] = ACCW'(EW'(acc_q[o]) + batch_sum[o]);
                state_d = S_OUT;
            end
            S_OUT: begin
                for (int unsigned o = 0; o < OUT_SIZE; o++)
                    y_d[o*BITSIZE +: BITSIZE] = act_sat(acc_q[o]);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            for (int unsigned o = 0; o < OUT_SIZE; o++) begin
                acc_q[o] <= '0;
                for (int unsigned j = 0; j < BATCH; j++)
                    prod_q[o][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;

endmodule

// File: tb/tb_dense_layer_batched.sv
// Directed bench for dense_layer_batched: one RELU=0 and one RELU=1 instance
// share the same operands and are checked against hand-computed results.
module tb_dense_layer_batched;

    localparam int BITSIZE  = 16;
    localparam int IN_SIZE  = 92;
    localparam int OUT_SIZE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                                start_r;
    logic [BITSIZE*IN_SIZE-1:0]          x_r;
    logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w_r;
    logic [BITSIZE*OUT_SIZE-1:0]         b_r;

    dense_layer_batched_if #(.BITSIZE(BITSIZE), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus0 ();
    dense_layer_batched_if #(.BITSIZE(BITSIZE), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus1 ();

    assign bus0.start = start_r;
    assign bus0.x     = x_r;
    assign bus0.w     = w_r;
    assign bus0.b     = b_r;
    assign bus1.start = start_r;
    assign bus1.x     = x_r;
    assign bus1.w     = w_r;
    assign bus1.b     = b_r;

    dense_layer_batched #(
        .BITSIZE(BITSIZE), .FRAC_BITS(8), .IN_SIZE(IN_SIZE),
        .OUT_SIZE(OUT_SIZE), .BATCH(32), .RELU(0)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    dense_layer_batched #(
        .BITSIZE(BITSIZE), .FRAC_BITS(8), .IN_SIZE(IN_SIZE),
        .OUT_SIZE(OUT_SIZE), .BATCH(32), .RELU(1)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int i = 0; i < IN_SIZE; i++)
            x_r[i*BITSIZE +: BITSIZE] = xv;
        for (int i = 0; i < IN_SIZE*OUT_SIZE; i++)
            w_r[i*BITSIZE +: BITSIZE] = wv;
        for (int o = 0; o < OUT_SIZE; o++)
            b_r[o*BITSIZE +: BITSIZE] = bv;
    endtask

    // Single start pulse; checks latency, busy width, done pulse and both results.
    task automatic run(input string tag, input logic [63:0] exp0, input logic [63:0] exp1);
        int lat;
        int bcnt;
        bit seen;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        lat = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus0.busy) bcnt++;
            if (bus0.done) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd5);
        check({tag, "_relu_done"}, 64'(bus1.done), 64'd1);
        check({tag, "_y_relu0"}, 64'(bus0.y), exp0);
        check({tag, "_y_relu1"}, 64'(bus1.y), exp1);
        tick();
        check({tag, "_done_pulse"}, 64'(bus0.done), 64'd0);
    endtask

    task automatic test_ignore_start();
        int ndone;
        fill(16'h0100, 16'h0080, 16'h0000);
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus0.done) ndone++;
            tick();
        end
        check("ignore_start_done_count", 64'(ndone), 64'd1);
        check("ignore_start_y", 64'(bus0.y), {4{16'h2E00}});
        check("ignore_start_busy", 64'(bus0.busy), 64'd0);
    endtask

    task automatic test_abort();
        int ndone;
        fill(16'h0200, 16'h0080, 16'h0000);
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_busy", 64'(bus0.busy), 64'd0);
        check("abort_done", 64'(bus0.done), 64'd0);
        check("abort_y", 64'(bus0.y), 64'd0);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus0.done) ndone++;
            tick();
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run("after_abort", {4{16'h5C00}}, {4{16'h5C00}});
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        int last;
        bit seen;
        xs = '{16'h0100, 16'h0200, 16'h0080};
        ys = '{16'h2E00, 16'h5C00, 16'h1700};
        last = 0;
        fill(xs[0], 16'h0080, 16'h0000);
        start_r = 1'b1;
        for (int r = 0; r < 3; r++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick();
                if (bus0.done) seen = 1'b1;
            end
            check($sformatf("b2b%0d_done_seen", r), 64'(seen), 64'd1);
            check($sformatf("b2b%0d_y", r), 64'(bus0.y), {4{ys[r]}});
            if (r > 0)
                check($sformatf("b2b%0d_spacing", r), 64'(cyc - last), 64'd6);
            last = cyc;
            if (r < 2)
                fill(xs[r+1], 16'h0080, 16'h0000);
            else
                start_r = 1'b0;
        end
        tick();
        check("b2b_idle_after", 64'(bus0.busy), 64'd0);
    endtask

    initial begin
        start_r = 1'b0;
        fill(16'h0000, 16'h0000, 16'h0000);
        reset = 1'b1;
        repeat (3) tick();
        check("reset_busy", 64'(bus0.busy), 64'd0);
        check("reset_done", 64'(bus0.done), 64'd0);
        check("reset_y", 64'(bus0.y), 64'd0);
        check("reset_y_relu", 64'(bus1.y), 64'd0);

        // start together with reset is not accepted
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        reset = 1'b0;
        tick();
        check("start_in_reset_busy", 64'(bus0.busy), 64'd0);

        fill(16'h0100, 16'h0080, 16'h0000);
        run("basic", {4{16'h2E00}}, {4{16'h2E00}});

        fill(16'h0000, 16'h0000, 16'h0000);
        x_r[91*BITSIZE +: BITSIZE] = 16'h0100;
        for (int o = 0; o < OUT_SIZE; o++)
            w_r[(o*IN_SIZE + 91)*BITSIZE +: BITSIZE] = 16'((o + 1) * 256);
        run("channel_order", 64'h0400_0300_0200_0100, 64'h0400_0300_0200_0100);

        fill(16'h4000, 16'h0100, 16'h0000);
        run("sat_pos", {4{16'h7FFF}}, {4{16'h7FFF}});
        fill(16'h4000, 16'hFF00, 16'h0000);
        run("sat_neg", {4{16'h8000}}, 64'd0);

        fill(16'h0000, 16'h0000, 16'hFF00);
        run("bias_neg", {4{16'hFF00}}, 64'd0);
        fill(16'h0000, 16'h0000, 16'h0180);
        run("bias_pos", {4{16'h0180}}, {4{16'h0180}});

        test_ignore_start();
        test_abort();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
